// File: rtl/ysyx_22050019_ifu_fetch.sv
// Instruction-fetch stage sitting directly upstream of the icache.
// Holds the PC and issues line-aligned read requests. The last returned line is kept
// in a one-entry line buffer, so sequential fetches within a line need no icache
// traffic. The selected instruction and its PC go to the IDU over valid/ready.
// Redirects (branch/jump/trap) and fence.i invalidation are also handled here.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   redirect_valid_i/_pc_i     load a new PC and flush any in-flight fetch
//   fence_i_i                  invalidate the line buffer
//   ar_valid_o/_ready_i/_addr_o  icache read request, address {pc[31:4],4'b0}
//   r_data_valid_i/_ready_o    icache line return handshake
//   r_resp_i, r_data_i         response code (2'b00 = OKAY) and 128-bit line
//   inst_valid_o/_ready_i      IDU handshake
//   inst_o, pc_o, inst_fault_o instruction, its PC, fetch error flag
module ysyx_22050019_ifu_fetch #(
   parameter int unsigned              ADDR_WIDTH = 32,
   parameter int unsigned              LINE_WIDTH = 128,
   parameter int unsigned              INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   input  logic                  fence_i_i,
   output logic                  ar_valid_o,
   input  logic                  ar_ready_i,
   output logic [ADDR_WIDTH-1:0] ar_addr_o,
   input  logic                  r_data_valid_i,
   output logic                  r_data_ready_o,
   input  logic [1:0]            r_resp_i,
   input  logic [LINE_WIDTH-1:0] r_data_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  inst_fault_o
);

   localparam int unsigned TagWidth = ADDR_WIDTH - 4;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  lb_valid_q, lb_valid_d;
   logic [TagWidth-1:0]   lb_tag_q, lb_tag_d;
   logic [LINE_WIDTH-1:0] lb_data_q, lb_data_d;
   logic                  drop_q, drop_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
   logic                  fault_q, fault_d;

   logic                  lb_hit;
   logic [INST_WIDTH-1:0] lb_word;
   logic [INST_WIDTH-1:0] r_word;

   assign lb_hit  = lb_valid_q && (pc_q[ADDR_WIDTH-1:4] == lb_tag_q);
   // pc[1:0] is ignored for word select.
   assign lb_word = lb_data_q[{pc_q[3:2], 5'b0} +: INST_WIDTH];
   assign r_word  = r_data_i[{pc_q[3:2], 5'b0} +: INST_WIDTH];

   // Address is forced to zero while idle so every output is zero during reset.
   assign ar_addr_o    = (state_q == StIdle) ? '0 : {pc_q[ADDR_WIDTH-1:4], 4'b0};
   assign inst_o       = inst_q;
   assign pc_o         = pc_out_q;
   assign inst_fault_o = fault_q;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      lb_valid_d     = lb_valid_q;
      lb_tag_d       = lb_tag_q;
      lb_data_d      = lb_data_q;
      drop_d         = drop_q;
      inst_d         = inst_q;
      pc_out_d       = pc_out_q;
      fault_d        = fault_q;
      ar_valid_o     = 1'b0;
      r_data_ready_o = 1'b0;
      inst_valid_o   = 1'b0;

      unique case (state_q)
         StIdle: state_d = StIssue;

         StIssue: begin
            ar_valid_o = !lb_hit;
            if (redirect_valid_i) begin
               pc_d = redirect_pc_i;
               // A request already accepted must still be drained, then dropped.
               if (!lb_hit && ar_ready_i) begin
                  state_d = StWait;
                  drop_d  = 1'b1;
               end
            end else if (lb_hit) begin
               inst_d   = lb_word;
               pc_out_d = pc_q;
               fault_d  = 1'b0;
               state_d  = StOut;
            end else if (ar_ready_i) begin
               state_d = StWait;
            end
         end

         StWait: begin
            r_data_ready_o = 1'b1;
            if (redirect_valid_i) pc_d = redirect_pc_i;
            if (r_data_valid_i) begin
               if (drop_q || redirect_valid_i) begin
                  drop_d  = 1'b0;
                  state_d = StIssue;
               end else if (r_resp_i == 2'b00) begin
                  lb_data_d  = r_data_i;
                  lb_tag_d   = pc_q[ADDR_WIDTH-1:4];
                  lb_valid_d = 1'b1;
                  inst_d     = r_word;
                  pc_out_d   = pc_q;
                  fault_d    = 1'b0;
                  state_d    = StOut;
               end else begin
                  lb_valid_d = 1'b0;
                  inst_d     = '0;
                  pc_out_d   = pc_q;
                  fault_d    = 1'b1;
                  state_d    = StOut;
               end
            end else if (redirect_valid_i) begin
               drop_d = 1'b1;
            end
         end

         StOut: begin
            inst_valid_o = 1'b1;
            if (redirect_valid_i) begin
               // Any same-cycle handshake is squashed by the downstream flush.
               pc_d    = redirect_pc_i;
               fault_d = 1'b0;
               state_d = StIssue;
            end else if (inst_ready_i) begin
               pc_d    = pc_q + ADDR_WIDTH'(4);
               fault_d = 1'b0;
               state_d = StIssue;
            end
         end

         default: state_d = StIdle;
      endcase

      // Invalidate wins over a coincident fill.
      if (fence_i_i) lb_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         lb_valid_q <= 1'b0;
         lb_tag_q   <= '0;
         lb_data_q  <= '0;
         drop_q     <= 1'b0;
         inst_q     <= '0;
         pc_out_q   <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         lb_valid_q <= lb_valid_d;
         lb_tag_q   <= lb_tag_d;
         lb_data_q  <= lb_data_d;
         drop_q     <= drop_d;
         inst_q     <= inst_d;
         pc_out_q   <= pc_out_d;
         fault_q    <= fault_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_ifu_fetch.sv
// Directed testbench for ysyx_22050019_ifu_fetch. The bench plays the icache and the
// IDU by hand; all inputs change and all outputs are sampled 1 ns after a rising edge.
module tb_ysyx_22050019_ifu_fetch;

   logic         clk = 1'b0;
   logic         rst;
   logic         redirect_valid_i;
   logic [31:0]  redirect_pc_i;
   logic         fence_i_i;
   logic         ar_valid_o;
   logic         ar_ready_i;
   logic [31:0]  ar_addr_o;
   logic         r_data_valid_i;
   logic         r_data_ready_o;
   logic [1:0]   r_resp_i;
   logic [127:0] r_data_i;
   logic         inst_valid_o;
   logic         inst_ready_i;
   logic [31:0]  inst_o;
   logic [31:0]  pc_o;
   logic         inst_fault_o;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] Line0 = 128'h00300093_00200093_00100093_00000013;
   localparam logic [127:0] Line1 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
   localparam logic [127:0] Stale = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

   always #5 clk = ~clk;

   ysyx_22050019_ifu_fetch dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .fence_i_i        (fence_i_i),
      .ar_valid_o       (ar_valid_o),
      .ar_ready_i       (ar_ready_i),
      .ar_addr_o        (ar_addr_o),
      .r_data_valid_i   (r_data_valid_i),
      .r_data_ready_o   (r_data_ready_o),
      .r_resp_i         (r_resp_i),
      .r_data_i         (r_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_o           (inst_o),
      .pc_o             (pc_o),
      .inst_fault_o     (inst_fault_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept the pending ar request, then return one line with the given response.
   task automatic serve(input logic [127:0] line, input logic [1:0] resp);
      ar_ready_i = 1'b1;
      step();
      ar_ready_i     = 1'b0;
      r_data_valid_i = 1'b1;
      r_data_i       = line;
      r_resp_i       = resp;
      step();
      r_data_valid_i = 1'b0;
      r_resp_i       = 2'b00;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] hold_inst;
      logic [31:0] hold_pc;
      logic [31:0] words [4];
      words[0] = 32'h00000013;
      words[1] = 32'h00100093;
      words[2] = 32'h00200093;
      words[3] = 32'h00300093;

      rst              = 1'b1;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      fence_i_i        = 1'b0;
      ar_ready_i       = 1'b0;
      r_data_valid_i   = 1'b0;
      r_resp_i         = 2'b00;
      r_data_i         = '0;
      inst_ready_i     = 1'b0;

      // Reset: all outputs zero.
      step();
      step();
      check_eq("rst_ar_valid", 32'(ar_valid_o), 32'd0);
      check_eq("rst_ar_addr", ar_addr_o, 32'd0);
      check_eq("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      check_eq("rst_inst", inst_o, 32'd0);
      check_eq("rst_pc", pc_o, 32'd0);
      check_eq("rst_fault", 32'(inst_fault_o), 32'd0);

      // Test 1: first fetch after reset.
      rst = 1'b0;
      step();
      check_eq("t1_ar_valid", 32'(ar_valid_o), 32'd1);
      check_eq("t1_ar_addr", ar_addr_o, 32'h8000_0000);
      ar_ready_i = 1'b1;
      step();
      ar_ready_i = 1'b0;
      check_eq("t1_r_ready", 32'(r_data_ready_o), 32'd1);
      check_eq("t1_ar_idle", 32'(ar_valid_o), 32'd0);
      r_data_valid_i = 1'b1;
      r_data_i       = Line0;
      step();
      r_data_valid_i = 1'b0;
      check_eq("t1_inst_valid", 32'(inst_valid_o), 32'd1);
      check_eq("t1_inst", inst_o, 32'h0000_0013);
      check_eq("t1_pc", pc_o, 32'h8000_0000);
      check_eq("t1_fault", 32'(inst_fault_o), 32'd0);

      // Test 2: remaining three words come from the line buffer.
      inst_ready_i = 1'b1;
      for (int k = 1; k < 4; k++) begin
         step();
         check_eq("t2_no_ar", 32'(ar_valid_o), 32'd0);
         step();
         check_eq("t2_inst_valid", 32'(inst_valid_o), 32'd1);
         check_eq("t2_inst", inst_o, words[k]);
         check_eq("t2_pc", pc_o, 32'h8000_0000 + 32'(4 * k));
      end
      step();
      inst_ready_i = 1'b0;
      check_eq("t2_next_ar_valid", 32'(ar_valid_o), 32'd1);
      check_eq("t2_next_ar_addr", ar_addr_o, 32'h8000_0010);

      // Test 3: redirect while waiting; stale line dropped.
      ar_ready_i = 1'b1;
      step();
      ar_ready_i       = 1'b0;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0104;
      step();
      redirect_valid_i = 1'b0;
      r_data_valid_i   = 1'b1;
      r_data_i         = Stale;
      step();
      r_data_valid_i = 1'b0;
      check_eq("t3_no_out", 32'(inst_valid_o), 32'd0);
      check_eq("t3_ar_valid", 32'(ar_valid_o), 32'd1);
      check_eq("t3_ar_addr", ar_addr_o, 32'h8000_0100);
      serve(Line1, 2'b00);
      check_eq("t3_inst", inst_o, 32'hBBBB_0002);
      check_eq("t3_pc", pc_o, 32'h8000_0104);

      // Test 4: back-pressure holds outputs; exactly one pc+4 on release.
      hold_inst = inst_o;
      hold_pc   = pc_o;
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("t4_hold_valid", 32'(inst_valid_o), 32'd1);
         check_eq("t4_hold_inst", inst_o, hold_inst);
         check_eq("t4_hold_pc", pc_o, hold_pc);
      end
      inst_ready_i = 1'b1;
      step();
      inst_ready_i = 1'b0;
      check_eq("t4_released", 32'(inst_valid_o), 32'd0);
      step();
      check_eq("t4_next_inst", inst_o, 32'hCCCC_0003);
      check_eq("t4_next_pc", pc_o, 32'h8000_0108);

      // Test 5: error response.
      inst_ready_i = 1'b1;
      step();
      step();
      check_eq("t5_last_word", inst_o, 32'hDDDD_0004);
      step();
      inst_ready_i = 1'b0;
      check_eq("t5_ar_addr", ar_addr_o, 32'h8000_0110);
      serve(Line0, 2'b10);
      check_eq("t5_fault", 32'(inst_fault_o), 32'd1);
      check_eq("t5_inst_zero", inst_o, 32'd0);
      check_eq("t5_pc", pc_o, 32'h8000_0110);
      inst_ready_i = 1'b1;
      step();
      inst_ready_i = 1'b0;
      check_eq("t5_fault_clr", 32'(inst_fault_o), 32'd0);
      check_eq("t5_refetch_valid", 32'(ar_valid_o), 32'd1);
      check_eq("t5_refetch_addr", ar_addr_o, 32'h8000_0110);

      // Test 6: redirect back to 0x80000000 (no handshake), refill, then fence.i.
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0000;
      step();
      redirect_valid_i = 1'b0;
      check_eq("t6_ar_addr", ar_addr_o, 32'h8000_0000);
      serve(Line0, 2'b00);
      check_eq("t6_inst", inst_o, 32'h0000_0013);
      fence_i_i    = 1'b1;
      inst_ready_i = 1'b1;
      step();
      fence_i_i    = 1'b0;
      inst_ready_i = 1'b0;
      check_eq("t6_fence_miss", 32'(ar_valid_o), 32'd1);
      check_eq("t6_fence_addr", ar_addr_o, 32'h8000_0000);

      // Fence coinciding with a fill: the line is used but not retained.
      ar_ready_i = 1'b1;
      step();
      ar_ready_i     = 1'b0;
      r_data_valid_i = 1'b1;
      r_data_i       = Line0;
      fence_i_i      = 1'b1;
      step();
      r_data_valid_i = 1'b0;
      fence_i_i      = 1'b0;
      check_eq("t6_fill_inst", inst_o, 32'h0010_0093);
      check_eq("t6_fill_pc", pc_o, 32'h8000_0004);
      inst_ready_i = 1'b1;
      step();
      inst_ready_i = 1'b0;
      check_eq("t6_fill_inval", 32'(ar_valid_o), 32'd1);
      check_eq("t6_fill_inval_addr", ar_addr_o, 32'h8000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
